// File: rtl/regfile_wb_arbiter_if.sv
// Write-request bundle shared by the two register-file writers (WB stage A,
// multi-cycle unit B) and the arbiter that grants them.
interface regfile_wb_arbiter_if;
   logic        a_valid;
   logic [4:0]  a_reg;
   logic [31:0] a_data;
   logic        a_ready;
   logic        b_valid;
   logic [4:0]  b_reg;
   logic [31:0] b_data;
   logic        b_ready;

   modport master (
      output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
      input  a_ready, b_ready
   );

   modport slave (
      input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
      output a_ready, b_ready
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter between two register-file writers with a registered
// write port and a saturating count of issued writes.
module regfile_wb_arbiter #(
   parameter bit PRIO_INIT = 1'b0,
   parameter int CNT_W     = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   regfile_wb_arbiter_if.slave  req,
   output logic                 RegWrite,
   output logic [4:0]           wr_reg,
   output logic [31:0]          wr_data,
   output logic                 prio,
   output logic [CNT_W-1:0]     wr_count
);

   typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prioState_e;
   localparam prioState_e INIT_STATE = prioState_e'(PRIO_INIT);

   prioState_e       state_q, state_d;
   logic             grantA, grantB;
   logic             wrEn_q, wrEn_d;
   logic [4:0]       wrReg_q, wrReg_d;
   logic [31:0]      wrData_q, wrData_d;
   logic [CNT_W-1:0] wrCount_q, wrCount_d;
   logic [4:0]       selReg;
   logic [31:0]      selData;
   logic             doWrite;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= INIT_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   // Priority always passes to the requester that was not just served.
   always_comb begin
      state_d = state_q;
      if (grantA) begin
         state_d = PRIO_B;
      end else if (grantB) begin
         state_d = PRIO_A;
      end
   end

   always_comb begin
      grantA = 1'b0;
      grantB = 1'b0;
      if (!reset) begin
         if (req.a_valid && (!req.b_valid || state_q == PRIO_A)) begin
            grantA = 1'b1;
         end else if (req.b_valid) begin
            grantB = 1'b1;
         end
      end
   end

   assign req.a_ready = grantA;
   assign req.b_ready = grantB;

   // A transfer to r0 is accepted but dropped, leaving the write port untouched.
   always_comb begin
      selReg    = grantA ? req.a_reg  : req.b_reg;
      selData   = grantA ? req.a_data : req.b_data;
      doWrite   = (grantA || grantB) && (selReg != 5'd0);
      wrEn_d    = doWrite;
      wrReg_d   = doWrite ? selReg  : wrReg_q;
      wrData_d  = doWrite ? selData : wrData_q;
      wrCount_d = wrCount_q;
      if (doWrite && (wrCount_q != {CNT_W{1'b1}})) begin
         wrCount_d = wrCount_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wrEn_q    <= 1'b0;
         wrReg_q   <= 5'd0;
         wrData_q  <= 32'd0;
         wrCount_q <= '0;
      end else begin
         wrEn_q    <= wrEn_d;
         wrReg_q   <= wrReg_d;
         wrData_q  <= wrData_d;
         wrCount_q <= wrCount_d;
      end
   end

   assign RegWrite = wrEn_q;
   assign wr_reg   = wrReg_q;
   assign wr_data  = wrData_q;
   assign wr_count = wrCount_q;
   assign prio     = state_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a vector table on the default
// instance plus a saturation/initial-priority sequence on a narrow-counter one.
module tb_regfile_wb_arbiter;

   typedef struct {
      logic        rst;
      logic        av;
      logic [4:0]  areg;
      logic [31:0] adata;
      logic        bv;
      logic [4:0]  breg;
      logic [31:0] bdata;
      logic        expAR;
      logic        expBR;
      logic        expWe;
      logic [4:0]  expReg;
      logic [31:0] expData;
      logic [15:0] expCount;
      logic        expPrio;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  regNum;
      logic [31:0] data;
      logic [15:0] count;
      logic        prio;
   } expOut_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        RegWrite, satRegWrite;
   logic [4:0]  wr_reg, satWrReg;
   logic [31:0] wr_data, satWrData;
   logic        prio, satPrio;
   logic [15:0] wr_count;
   logic [3:0]  satWrCount;

   int checks = 0;
   int errors = 0;
   vec_t    vecs[$];
   expOut_t sbQ[$];

   regfile_wb_arbiter_if bus();
   regfile_wb_arbiter_if satBus();

   always #5 clock = ~clock;

   regfile_wb_arbiter dut (
      .clock    (clock),
      .reset    (reset),
      .req      (bus),
      .RegWrite (RegWrite),
      .wr_reg   (wr_reg),
      .wr_data  (wr_data),
      .prio     (prio),
      .wr_count (wr_count)
   );

   regfile_wb_arbiter #(.PRIO_INIT(1'b1), .CNT_W(4)) dutSat (
      .clock    (clock),
      .reset    (reset),
      .req      (satBus),
      .RegWrite (satRegWrite),
      .wr_reg   (satWrReg),
      .wr_data  (satWrData),
      .prio     (satPrio),
      .wr_count (satWrCount)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives one vector shortly after a rising edge, checks the combinational
   // readies, then checks the registered result one edge later via the queue.
   task automatic applyStimulus(input int idx, input vec_t v);
      expOut_t e;
      reset        = v.rst;
      bus.a_valid  = v.av;
      bus.a_reg    = v.areg;
      bus.a_data   = v.adata;
      bus.b_valid  = v.bv;
      bus.b_reg    = v.breg;
      bus.b_data   = v.bdata;
      #3;
      checkOutput($sformatf("v%0d a_ready", idx), {31'd0, bus.a_ready}, {31'd0, v.expAR});
      checkOutput($sformatf("v%0d b_ready", idx), {31'd0, bus.b_ready}, {31'd0, v.expBR});
      sbQ.push_back('{we: v.expWe, regNum: v.expReg, data: v.expData, count: v.expCount, prio: v.expPrio});
      @(posedge clock);
      #1;
      if (sbQ.size() == 0) begin
         checkOutput($sformatf("v%0d scoreboard", idx), 32'd0, 32'd1);
      end else begin
         e = sbQ.pop_front();
         checkOutput($sformatf("v%0d RegWrite", idx), {31'd0, RegWrite}, {31'd0, e.we});
         checkOutput($sformatf("v%0d wr_reg", idx),   {27'd0, wr_reg},   {27'd0, e.regNum});
         checkOutput($sformatf("v%0d wr_data", idx),  wr_data,           e.data);
         checkOutput($sformatf("v%0d wr_count", idx), {16'd0, wr_count}, {16'd0, e.count});
         checkOutput($sformatf("v%0d prio", idx),     {31'd0, prio},     {31'd0, e.prio});
      end
   endtask

   initial begin
      expOut_t e;
      int      expCnt;

      // rst av areg adata bv breg bdata | aR bR | we reg data count prio (after edge)
      vecs.push_back('{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        16'd0, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        16'd0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 16'd1, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 16'd1, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFF, 1'b0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 16'd1, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 5'd3, 32'hA1,       1'b1, 5'd4, 32'hB1, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA1,       16'd2, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 5'd3, 32'hA1,       1'b1, 5'd4, 32'hB1, 1'b0, 1'b1, 1'b1, 5'd4, 32'hB1,       16'd3, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 5'd3, 32'hA1,       1'b1, 5'd4, 32'hB1, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA1,       16'd4, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd3, 32'hA1,       16'd4, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 1'b1, 5'd9, 32'h99,       16'd5, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22, 1'b1, 1'b0, 1'b1, 5'd7, 32'h11,       16'd6, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h22, 1'b0, 1'b1, 1'b1, 5'd7, 32'h22,       16'd7, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 5'd0, 32'h55,       1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd7, 32'h22,       16'd7, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 5'd2, 32'h2222,     1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd2, 32'h2222,     16'd8, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 5'd6, 32'h6666,     1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        16'd0, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 5'd1, 32'h1,        1'b1, 5'd2, 32'h2,  1'b1, 1'b0, 1'b1, 5'd1, 32'h1,        16'd1, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd1, 32'h1,        16'd1, 1'b1});

      reset          = 1'b1;
      bus.a_valid    = 1'b0;
      bus.a_reg      = 5'd0;
      bus.a_data     = 32'd0;
      bus.b_valid    = 1'b0;
      bus.b_reg      = 5'd0;
      bus.b_data     = 32'd0;
      satBus.a_valid = 1'b0;
      satBus.a_reg   = 5'd0;
      satBus.a_data  = 32'd0;
      satBus.b_valid = 1'b0;
      satBus.b_reg   = 5'd0;
      satBus.b_data  = 32'd0;
      @(posedge clock);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(i, vecs[i]);
      end

      // Narrow-counter instance: starts with B priority and saturates at 15.
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      checkOutput("sat prio after reset",  {31'd0, satPrio},    32'd1);
      checkOutput("sat count after reset", {28'd0, satWrCount}, 32'd0);

      satBus.a_valid = 1'b1;
      satBus.a_reg   = 5'd1;
      satBus.a_data  = 32'hA0;
      satBus.b_valid = 1'b1;
      satBus.b_reg   = 5'd2;
      satBus.b_data  = 32'hB0;
      #3;
      checkOutput("sat contention a_ready", {31'd0, satBus.a_ready}, 32'd0);
      checkOutput("sat contention b_ready", {31'd0, satBus.b_ready}, 32'd1);
      @(posedge clock);
      #1;
      checkOutput("sat first wr_reg",  {27'd0, satWrReg}, 32'd2);
      checkOutput("sat first wr_data", satWrData,         32'hB0);
      checkOutput("sat first prio",    {31'd0, satPrio},  32'd0);

      satBus.b_valid = 1'b0;
      expCnt = 1;
      for (int i = 1; i <= 20; i++) begin
         satBus.a_data = 32'(i);
         #3;
         checkOutput($sformatf("sat%0d a_ready", i), {31'd0, satBus.a_ready}, 32'd1);
         expCnt = (expCnt < 15) ? expCnt + 1 : 15;
         sbQ.push_back('{we: 1'b1, regNum: 5'd1, data: 32'(i), count: 16'(expCnt), prio: 1'b1});
         @(posedge clock);
         #1;
         if (sbQ.size() == 0) begin
            checkOutput($sformatf("sat%0d scoreboard", i), 32'd0, 32'd1);
         end else begin
            e = sbQ.pop_front();
            checkOutput($sformatf("sat%0d RegWrite", i), {31'd0, satRegWrite}, {31'd0, e.we});
            checkOutput($sformatf("sat%0d wr_data", i),  satWrData,            e.data);
            checkOutput($sformatf("sat%0d wr_count", i), {28'd0, satWrCount},  {16'd0, e.count});
         end
      end

      satBus.a_valid = 1'b0;
      @(posedge clock);
      #1;
      checkOutput("sat idle RegWrite", {31'd0, satRegWrite}, 32'd0);
      checkOutput("sat idle wr_count", {28'd0, satWrCount},  32'd15);
      checkOutput("sat idle wr_data",  satWrData,            32'd20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, 0, requester holding priority after reset (0 = A, 1 = B).
REQ-002 Parameter: CNT_W, 16, width of write counter wr_count.
REQ-003 clock  in  1  single clock; all state updates on posedge clock.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on posedge clock.
REQ-005 a_valid  in  1  requester A (pipeline WB stage) has a write pending.
REQ-006 a_reg  in  5  requester A destination register.
REQ-007 a_data  in  32  requester A write data.
REQ-008 a_ready  out  1  A's request accepted this cycle.
REQ-009 b_valid  in  1  requester B (multi-cycle unit) has a write pending.
REQ-010 b_reg  in  5  requester B destination register.
REQ-011 b_data  in  32  requester B write data.
REQ-012 b_ready  out  1  B's request accepted this cycle.
REQ-013 RegWrite  out  1  register-file write enable (drives RegFile RegWrite).
REQ-014 wr_reg  out  5  register-file write address.
REQ-015 wr_data  out  32  register-file write data.
REQ-016 prio  out  1  current priority pointer (0 = A, 1 = B).
REQ-017 wr_count  out  CNT_W  number of RegWrite pulses issued since reset, saturating.

Function
REQ-018 Transfer on a port SHALL occur in a cycle where valid and ready are both 1 at posedge clock.
REQ-019 a_ready/b_ready SHALL be combinational from valids and prio; requesters SHALL NOT make valid depend on ready.
REQ-020 Only one requester: that requester's ready SHALL be 1; neither valid: both readies 0.
REQ-021 Both valid: ready SHALL go to the requester named by prio; the other's ready SHALL be 0.
REQ-022 a_ready and b_ready SHALL never be 1 in the same cycle.
REQ-023 Priority FSM has two states, PRIO_A and PRIO_B; after any transfer prio SHALL move to the non-granted requester; with no transfer prio SHALL hold.
REQ-024 A stalled requester SHALL keep valid, reg and data stable until ready; arbiter guarantees service within 2 cycles under continuous contention.
REQ-025 Output stage is registered: transfer at edge N SHALL drive RegWrite=1, wr_reg, wr_data throughout cycle N+1 so the register file commits at edge N+1.
REQ-026 No transfer at edge N: RegWrite SHALL be 0 in cycle N+1; wr_reg/wr_data SHALL hold previous values.
REQ-027 Transfer with reg = 0 SHALL be accepted (ready asserted) but SHALL produce RegWrite=0 in the following cycle and no count increment.
REQ-028 Back-to-back transfers SHALL sustain one write per cycle with no bubble.
REQ-029 Simultaneous requests to the same register SHALL be serialized by priority; later-granted data SHALL be the final register value.
REQ-030 wr_count SHALL increment by 1 on each cycle with RegWrite=1 and SHALL saturate at 2^CNT_W-1 (no wrap).

Reset
REQ-031 reset=1 at an edge SHALL set RegWrite=0, wr_reg=0, wr_data=0, wr_count=0, prio=PRIO_INIT.
REQ-032 While reset=1, a_ready and b_ready SHALL be 0; no transfer occurs.
REQ-033 Reset asserted in the cycle after a transfer SHALL cancel that pending write (RegWrite=0 in the next cycle).
REQ-034 First edge with reset=0 SHALL arbitrate normally from PRIO_INIT.

Verification
REQ-035 Reset, then a_valid=1 a_reg=5 a_data=0xDEADBEEF, b_valid=0 -> a_ready=1; next cycle RegWrite=1 wr_reg=5 wr_data=0xDEADBEEF; wr_count=1.
REQ-036 PRIO_INIT=0, both valid 3 cycles (a_reg=3, b_reg=4) -> grants A,B,A; prio 1,0,1; RegWrite high 3 consecutive cycles; final wr_count=3.
REQ-037 Both valid, both reg=7, a_data=0x11, b_data=0x22, prio=0 -> writes 0x11 then 0x22 to r7 on consecutive cycles.
REQ-038 b_valid=1 b_reg=0 b_data=0xFF -> b_ready=1; next cycle RegWrite=0; wr_count unchanged; prio moves to 0.
REQ-039 Transfer at edge N, reset=1 at edge N+1 -> RegWrite=0 after edge N+1; wr_count=0; prio=PRIO_INIT.
REQ-040 CNT_W=4, 20 consecutive A writes to r1 -> wr_count reaches 15 and holds at 15.
